hs_fifo_buf: RTL and testbench

- Parametrised successor to the single-entry request/acknowledge buffer: a DEPTH-entry, WIDTH-bit FIFO.
- Sits between a sender and a receiver, using 4-phase REQ/ACK handshakes on both sides.
- Decouples the two sides, so the sender can complete up to DEPTH transfers while the receiver stalls.
- Fully synchronous to clk; all handshake inputs come from the same clock domain (no synchronisers).

---
 rtl/hs_fifo_pkg.sv | 22 ++
 rtl/hs_fifo_mem.sv | 27 ++
 rtl/hs_fifo_buf.sv | 192 +++++++++++++++++++
 tb/tb_hs_fifo_buf.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/hs_fifo_pkg.sv
// Shared types for the hs_fifo_buf handshake FIFO: FSM state encodings and
// the occupancy-count width helper.
package hs_fifo_pkg;

  typedef enum logic {
    I_IDLE = 1'b0,
    I_ACK  = 1'b1
  } in_state_t;

  typedef enum logic [1:0] {
    O_IDLE  = 2'd0,
    O_SETUP = 2'd1,
    O_REQ   = 2'd2,
    O_WAIT  = 2'd3
  } out_state_t;

  // Count must represent 0..DEPTH inclusive, hence one bit above the pointer width.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/hs_fifo_mem.sv
// DEPTH x WIDTH storage array for hs_fifo_buf: synchronous write port,
// asynchronous read port. Contents are not reset.
module hs_fifo_mem #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/hs_fifo_buf.sv
// DEPTH-entry FIFO between 4-phase REQ/ACK sender and receiver interfaces.
// Optional protocol checker enabled by defining HS_FIFO_BUF_PROTOCOL_CHECK_EN.
module hs_fifo_buf
  import hs_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = count_width(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             StoB_REQ,
  input  logic [WIDTH-1:0] DI,
  output logic             BtoS_ACK,
  output logic             BtoR_REQ,
  output logic [WIDTH-1:0] DO,
  input  logic             RtoB_ACK,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty,
  output logic             proto_err
);

  localparam int AW = $clog2(DEPTH);

  in_state_t        in_state, in_next;
  out_state_t       out_state, out_next;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    cnt_next;
  logic [WIDTH-1:0] rdata;
  logic             wr_en, pop, load, ack_next, req_next;

  hs_fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr),
    .wdata (DI),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Sender side: accept a word only when there is room, then hold ACK until REQ drops
  always_comb begin
    in_next  = in_state;
    wr_en    = 1'b0;
    ack_next = 1'b0;
    case (in_state)
      I_IDLE: begin
        if (StoB_REQ && !full) begin
          wr_en    = 1'b1;
          ack_next = 1'b1;
          in_next  = I_ACK;
        end else begin
          in_next  = I_IDLE;
        end
      end
      I_ACK: begin
        if (StoB_REQ) begin
          ack_next = 1'b1;
          in_next  = I_ACK;
        end else begin
          in_next  = I_IDLE;
        end
      end
      default: in_next = I_IDLE;
    endcase
  end

  // Receiver side: load DO one cycle ahead of REQ so data is stable at REQ rise
  always_comb begin
    out_next = out_state;
    load     = 1'b0;
    pop      = 1'b0;
    req_next = 1'b0;
    case (out_state)
      O_IDLE: begin
        if (!empty) begin
          load     = 1'b1;
          out_next = O_SETUP;
        end else begin
          out_next = O_IDLE;
        end
      end
      O_SETUP: begin
        req_next = 1'b1;
        out_next = O_REQ;
      end
      O_REQ: begin
        if (RtoB_ACK) begin
          pop      = 1'b1;
          out_next = O_WAIT;
        end else begin
          req_next = 1'b1;
          out_next = O_REQ;
        end
      end
      O_WAIT: begin
        if (RtoB_ACK) begin
          out_next = O_WAIT;
        end else begin
          out_next = O_IDLE;
        end
      end
      default: out_next = O_IDLE;
    endcase
  end

  // Occupancy next value; a simultaneous write and pop cancel out
  always_comb begin
    case ({wr_en, pop})
      2'b10:   cnt_next = count + CW'(1);
      2'b01:   cnt_next = count - CW'(1);
      default: cnt_next = count;
    endcase
  end

  // State, pointers, occupancy and all outputs are registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_state  <= I_IDLE;
      out_state <= O_IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      full      <= 1'b0;
      empty     <= 1'b1;
      BtoS_ACK  <= 1'b0;
      BtoR_REQ  <= 1'b0;
      DO        <= '0;
    end else begin
      in_state  <= in_next;
      out_state <= out_next;
      BtoS_ACK  <= ack_next;
      BtoR_REQ  <= req_next;
      count     <= cnt_next;
      full      <= (cnt_next == CW'(DEPTH));
      empty     <= (cnt_next == CW'(0));
      if (wr_en) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      if (load) begin
        DO <= rdata;
      end
    end
  end

`ifdef HS_FIFO_BUF_PROTOCOL_CHECK_EN
  logic             refused, pend_prev, viol;
  logic [WIDTH-1:0] di_prev;

  // Violation: refused request withdrawn, DI unstable before ACK, or early receiver ACK
  always_comb begin
    viol = 1'b0;
    if ((in_state == I_IDLE) && refused && !StoB_REQ) begin
      viol = 1'b1;
    end else if (pend_prev && StoB_REQ && !BtoS_ACK && (DI != di_prev)) begin
      viol = 1'b1;
    end else if (RtoB_ACK && ((out_state == O_IDLE) || (out_state == O_SETUP))) begin
      viol = 1'b1;
    end else begin
      viol = 1'b0;
    end
  end

  // Checker history and the sticky error flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      refused   <= 1'b0;
      pend_prev <= 1'b0;
      di_prev   <= '0;
      proto_err <= 1'b0;
    end else begin
      pend_prev <= StoB_REQ && !BtoS_ACK;
      di_prev   <= DI;
      if ((in_state == I_IDLE) && StoB_REQ && full) begin
        refused <= 1'b1;
      end else if (wr_en || !StoB_REQ) begin
        refused <= 1'b0;
      end
      if (viol) begin
        proto_err <= 1'b1;
      end
    end
  end
`else
  assign proto_err = 1'b0;
`endif

endmodule

// File: tb/tb_hs_fifo_buf.sv
// Directed self-checking bench for hs_fifo_buf (WIDTH=32, DEPTH=4).
module tb_hs_fifo_buf;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        StoB_REQ = 1'b0;
  logic [31:0] DI = 32'd0;
  logic        BtoS_ACK, BtoR_REQ;
  logic [31:0] DO;
  logic        RtoB_ACK;
  logic [2:0]  count;
  logic        full, empty, proto_err;

  logic        rx_ack = 1'b0;
  logic        man_ack = 1'b0;
  logic        rx_en = 1'b0;
  int          rx_delay_max = 0;
  logic [31:0] rx_q[$];
  int          vectors = 0;
  int          miscompares = 0;

`ifdef HS_FIFO_BUF_PROTOCOL_CHECK_EN
  localparam logic PERR_EXP = 1'b1;
`else
  localparam logic PERR_EXP = 1'b0;
`endif

  assign RtoB_ACK = rx_ack | man_ack;

  hs_fifo_buf #(.WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .StoB_REQ(StoB_REQ), .DI(DI), .BtoS_ACK(BtoS_ACK),
    .BtoR_REQ(BtoR_REQ), .DO(DO), .RtoB_ACK(RtoB_ACK), .count(count),
    .full(full), .empty(empty), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full 4-phase sender transfer with bounded waits
  task automatic send(input logic [31:0] w);
    int k;
    DI = w;
    StoB_REQ = 1'b1;
    k = 0;
    do begin tick(); k++; end while (!BtoS_ACK && k < 200);
    check_vec("send_ack_hi", {31'd0, BtoS_ACK}, 32'd1);
    StoB_REQ = 1'b0;
    k = 0;
    do begin tick(); k++; end while (BtoS_ACK && k < 20);
    check_vec("send_ack_lo", {31'd0, BtoS_ACK}, 32'd0);
  endtask

  task automatic wait_rx(input int n);
    for (int k = 0; k < 2000 && rx_q.size() < n; k++) tick();
    check_vec("rx_count", rx_q.size(), n);
  endtask

  task automatic check_rx(input string tag, input logic [31:0] exp[$]);
    wait_rx(exp.size());
    for (int i = 0; i < exp.size() && i < rx_q.size(); i++) check_vec(tag, rx_q[i], exp[i]);
  endtask

  // Automatic receiver: capture DO at REQ, optional random delay, then 4-phase ACK
  initial begin
    int d;
    forever begin
      tick();
      if (rx_en && BtoR_REQ && !rx_ack) begin
        rx_q.push_back(DO);
        d = (rx_delay_max > 0) ? int'($urandom_range(rx_delay_max, 0)) : 0;
        repeat (d) tick();
        rx_ack = 1'b1;
        for (int k = 0; k < 20 && BtoR_REQ; k++) tick();
        rx_ack = 1'b0;
      end
    end
  end

  initial begin
    logic [31:0] exp_q[$];
    #1 rst = 1'b1;
    #1;
    check_vec("rst0_ack", {31'd0, BtoS_ACK}, 32'd0);
    check_vec("rst0_req", {31'd0, BtoR_REQ}, 32'd0);
    check_vec("rst0_cnt", {29'd0, count}, 32'd0);
    check_vec("rst0_empty", {31'd0, empty}, 32'd1);
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Single transfer with prompt receiver
    rx_en = 1'b1;
    rx_q.delete();
    DI = 32'h0000_0005;
    StoB_REQ = 1'b1;
    check_vec("t2_ack_pre", {31'd0, BtoS_ACK}, 32'd0);
    tick();
    check_vec("t2_ack_lat", {31'd0, BtoS_ACK}, 32'd1);
    check_vec("t2_count", {29'd0, count}, 32'd1);
    StoB_REQ = 1'b0;
    tick();
    check_vec("t2_ack_lo", {31'd0, BtoS_ACK}, 32'd0);
    exp_q = '{32'd5};
    check_rx("t2_data", exp_q);
    repeat (4) tick();
    check_vec("t2_cnt0", {29'd0, count}, 32'd0);
    check_vec("t2_empty", {31'd0, empty}, 32'd1);

    // Fill while receiver stalls, fifth request refused until space frees
    rx_en = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 4; i++) send(i);
    check_vec("t3_full", {31'd0, full}, 32'd1);
    check_vec("t3_count", {29'd0, count}, 32'd4);
    DI = 32'd4;
    StoB_REQ = 1'b1;
    repeat (5) tick();
    check_vec("t3_refused", {31'd0, BtoS_ACK}, 32'd0);
    check_vec("t3_do_head", DO, 32'd0);
    rx_en = 1'b1;
    send(32'd4);
    exp_q = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4};
    check_rx("t3_order", exp_q);
    repeat (4) tick();
    check_vec("t3_cnt0", {29'd0, count}, 32'd0);

    // Simultaneous write and pop at count=2
    rx_en = 1'b0;
    rx_q.delete();
    send(32'hA);
    send(32'hB);
    for (int k = 0; k < 20 && !BtoR_REQ; k++) tick();
    check_vec("t4_req", {31'd0, BtoR_REQ}, 32'd1);
    check_vec("t4_cnt2", {29'd0, count}, 32'd2);
    check_vec("t4_do", DO, 32'hA);
    DI = 32'hC;
    StoB_REQ = 1'b1;
    man_ack = 1'b1;
    tick();
    check_vec("t4_cnt_same", {29'd0, count}, 32'd2);
    check_vec("t4_ack", {31'd0, BtoS_ACK}, 32'd1);
    check_vec("t4_req_lo", {31'd0, BtoR_REQ}, 32'd0);
    StoB_REQ = 1'b0;
    man_ack = 1'b0;
    tick();
    rx_en = 1'b1;
    exp_q = '{32'hB, 32'hC};
    check_rx("t4_order", exp_q);
    repeat (4) tick();
    check_vec("t4_cnt0", {29'd0, count}, 32'd0);

    // Stream of 100 words with random receiver delays
    rx_q.delete();
    rx_delay_max = 5;
    exp_q.delete();
    for (int i = 0; i < 100; i++) begin
      send(i);
      exp_q.push_back(i);
    end
    check_rx("t5_stream", exp_q);
    rx_delay_max = 0;
    repeat (10) tick();
    check_vec("t5_cnt0", {29'd0, count}, 32'd0);
    check_vec("t5_no_perr", {31'd0, proto_err}, 32'd0);

    // DI changes under an unacknowledged request (FIFO full)
    rx_en = 1'b0;
    rx_q.delete();
    for (int i = 0; i < 4; i++) send(32'h100 + i);
    DI = 32'hAA;
    StoB_REQ = 1'b1;
    tick();
    check_vec("t6_pend", {31'd0, BtoS_ACK}, 32'd0);
    DI = 32'hBB;
    tick();
    check_vec("t6_perr", {31'd0, proto_err}, {31'd0, PERR_EXP});
    repeat (3) tick();
    check_vec("t6_sticky", {31'd0, proto_err}, {31'd0, PERR_EXP});

    // Asynchronous reset mid-handshake, checked before the next clock edge
    #3 rst = 1'b1;
    #1;
    check_vec("t1_ack", {31'd0, BtoS_ACK}, 32'd0);
    check_vec("t1_req", {31'd0, BtoR_REQ}, 32'd0);
    check_vec("t1_do", DO, 32'd0);
    check_vec("t1_cnt", {29'd0, count}, 32'd0);
    check_vec("t1_empty", {31'd0, empty}, 32'd1);
    check_vec("t1_full", {31'd0, full}, 32'd0);
    check_vec("t1_perr", {31'd0, proto_err}, 32'd0);
    StoB_REQ = 1'b0;
    DI = 32'd0;
    repeat (3) tick();
    rst = 1'b0;
    tick();

    // Stored words were discarded: only the new word comes out
    rx_en = 1'b1;
    send(32'h77);
    exp_q = '{32'h77};
    check_rx("t1_post", exp_q);
    repeat (10) tick();
    check_vec("t1_post_len", rx_q.size(), 32'd1);
    check_vec("t1_post_perr", {31'd0, proto_err}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
